// File: rtl/battleship_pkg.sv
// Shared Battleship encodings: game states, winner codes and default widths.
// Also used by the fire-permission and display logic.
package battleship_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_P1_PLACE  = 3'd1,
    ST_P2_PLACE  = 3'd2,
    ST_P1_TURN   = 3'd3,
    ST_P2_TURN   = 3'd4,
    ST_RESOLVE   = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int DEF_COORD_W      = 6;
  localparam int DEF_CNT_W        = 5;
  localparam int DEF_HITS_TO_WIN  = 17;
  localparam int DEF_TURN_TIMEOUT = 1000000;

  function automatic logic is_turn(input state_e s);
    return (s == ST_P1_TURN) || (s == ST_P2_TURN);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-cycle counter for one turn: o_expire is high on the last allowed cycle.
module turn_timer #(
  parameter int TURN_TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TURN_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TURN_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  assign o_expire = i_enable && (r_count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Battleship game-phase controller: placement, alternating single shots, hit counting, winner.
// Optional turn forfeit timer is built only when TURN_TIMEOUT_EN is defined.
module turn_sequencer
  import battleship_pkg::*;
#(
  parameter int COORD_W      = DEF_COORD_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int HITS_TO_WIN  = DEF_HITS_TO_WIN,
  parameter int TURN_TIMEOUT = DEF_TURN_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_place_done,
  input  logic               p2_place_done,
  input  logic               p1_fire_req,
  input  logic               p2_fire_req,
  input  logic [COORD_W-1:0] p1_coord,
  input  logic [COORD_W-1:0] p2_coord,
  input  logic               result_valid,
  input  logic               result_hit,
  output logic [2:0]         state,
  output logic               shot_valid,
  output logic               shot_player,
  output logic [COORD_W-1:0] shot_coord,
  output logic [CNT_W-1:0]   p1_hits,
  output logic [CNT_W-1:0]   p2_hits,
  output logic [1:0]         winner,
  output logic               turn_timeout
);

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(HITS_TO_WIN);

  // Empty marker block: only elaborates for an illegal parameter set.
  if (TURN_TIMEOUT < 2 || HITS_TO_WIN >= (1 << CNT_W)) begin : g_bad_params
  end

  state_e             r_state, w_next_state;
  logic               r_owner;
  logic               r_shot_valid, r_shot_player;
  logic [COORD_W-1:0] r_shot_coord;
  logic [CNT_W-1:0]   r_p1_hits, r_p2_hits;
  logic [1:0]         r_winner;

  logic               w_fire, w_fire_player, w_clear_scores, w_score, w_win, w_expire;
  logic [COORD_W-1:0] w_fire_coord;
  logic [CNT_W-1:0]   w_owner_hits, w_owner_inc;

  always_comb begin
    w_next_state   = r_state;
    w_fire         = 1'b0;
    w_fire_player  = 1'b0;
    w_fire_coord   = '0;
    w_clear_scores = 1'b0;
    w_score        = 1'b0;
    w_win          = 1'b0;
    w_owner_hits   = r_owner ? r_p2_hits : r_p1_hits;
    w_owner_inc    = (w_owner_hits < WIN_CNT) ? w_owner_hits + CNT_W'(1) : w_owner_hits;

    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          w_next_state   = ST_P1_PLACE;
          w_clear_scores = 1'b1;
        end
      end
      ST_P1_PLACE: if (p1_place_done) w_next_state = ST_P2_PLACE;
      ST_P2_PLACE: if (p2_place_done) w_next_state = ST_P1_TURN;
      // Only the owner's request counts; a request on the expiry cycle beats the forfeit.
      ST_P1_TURN: begin
        if (p1_fire_req) begin
          w_fire       = 1'b1;
          w_fire_coord = p1_coord;
          w_next_state = ST_RESOLVE;
        end else if (w_expire) begin
          w_next_state = ST_P2_TURN;
        end
      end
      ST_P2_TURN: begin
        if (p2_fire_req) begin
          w_fire        = 1'b1;
          w_fire_player = 1'b1;
          w_fire_coord  = p2_coord;
          w_next_state  = ST_RESOLVE;
        end else if (w_expire) begin
          w_next_state = ST_P1_TURN;
        end
      end
      ST_RESOLVE: begin
        if (result_valid) begin
          w_score = result_hit;
          w_win   = result_hit && (w_owner_inc == WIN_CNT);
          if (w_win)        w_next_state = ST_GAME_OVER;
          else if (r_owner) w_next_state = ST_P1_TURN;
          else              w_next_state = ST_P2_TURN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_shot_valid  <= 1'b0;
      r_shot_player <= 1'b0;
      r_shot_coord  <= '0;
      r_p1_hits     <= '0;
      r_p2_hits     <= '0;
      r_winner      <= WINNER_NONE;
    end else begin
      r_state      <= w_next_state;
      r_shot_valid <= w_fire;
      if (w_fire) begin
        r_owner       <= w_fire_player;
        r_shot_player <= w_fire_player;
        r_shot_coord  <= w_fire_coord;
      end
      if (w_clear_scores) begin
        r_p1_hits <= '0;
        r_p2_hits <= '0;
        r_winner  <= WINNER_NONE;
      end else if (w_score) begin
        if (r_owner) r_p2_hits <= w_owner_inc;
        else         r_p1_hits <= w_owner_inc;
        if (w_win) r_winner <= r_owner ? WINNER_P2 : WINNER_P1;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  logic r_turn_timeout;
  logic w_timer_clear, w_in_turn;

  assign w_in_turn     = is_turn(r_state);
  assign w_timer_clear = is_turn(w_next_state) && (w_next_state != r_state);

  turn_timer #(
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_turn_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_enable(w_in_turn),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_turn_timeout <= 1'b0;
    else        r_turn_timeout <= w_expire && !w_fire;
  end

  assign turn_timeout = r_turn_timeout;
`else
  assign w_expire     = 1'b0;
  assign turn_timeout = 1'b0;
`endif

  assign state       = r_state;
  assign shot_valid  = r_shot_valid;
  assign shot_player = r_shot_player;
  assign shot_coord  = r_shot_coord;
  assign p1_hits     = r_p1_hits;
  assign p2_hits     = r_p2_hits;
  assign winner      = r_winner;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed game scenarios plus random play against a game-rule model.
module tb_turn_sequencer;

  localparam int COORD_W = 6;
  localparam int CNT_W   = 5;
  localparam int HITS    = 3;
  localparam int TIMEOUT = 8;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               start, p1_place_done, p2_place_done, p1_fire_req, p2_fire_req;
  logic               result_valid, result_hit;
  logic [COORD_W-1:0] p1_coord, p2_coord;
  logic [2:0]         state;
  logic               shot_valid, shot_player, turn_timeout;
  logic [COORD_W-1:0] shot_coord;
  logic [CNT_W-1:0]   p1_hits, p2_hits;
  logic [1:0]         winner;

  turn_sequencer #(
    .COORD_W(COORD_W), .CNT_W(CNT_W), .HITS_TO_WIN(HITS), .TURN_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_place_done(p1_place_done), .p2_place_done(p2_place_done),
    .p1_fire_req(p1_fire_req), .p2_fire_req(p2_fire_req),
    .p1_coord(p1_coord), .p2_coord(p2_coord),
    .result_valid(result_valid), .result_hit(result_hit),
    .state(state), .shot_valid(shot_valid), .shot_player(shot_player),
    .shot_coord(shot_coord), .p1_hits(p1_hits), .p2_hits(p2_hits),
    .winner(winner), .turn_timeout(turn_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // game-rule reference model
  int               m_phase;   // 0 idle,1 p1 place,2 p2 place,3 p1 turn,4 p2 turn,5 resolve,6 over
  int               m_owner, m_idle, m_winner;
  int               m_hits[2];
  bit               m_sv, m_sp, m_to;
  logic [COORD_W-1:0] m_sc;
  logic [COORD_W:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_idle = 0; m_winner = 0;
    m_hits[0] = 0; m_hits[1] = 0;
    m_sv = 0; m_sp = 0; m_to = 0; m_sc = '0;
    exp_q.delete();
  endtask

  task automatic new_game();
    m_phase = 1; m_hits[0] = 0; m_hits[1] = 0; m_winner = 0;
  endtask

  task automatic model_step();
    bit req;
    int p;
    m_sv = 0;
    m_to = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      0, 6: if (start) new_game();
      1: if (p1_place_done) m_phase = 2;
      2: if (p2_place_done) begin m_phase = 3; m_idle = 0; end
      3, 4: begin
        p   = m_phase - 3;
        req = (p == 1) ? p2_fire_req : p1_fire_req;
        if (req) begin
          m_sv = 1; m_sp = p[0]; m_sc = (p == 1) ? p2_coord : p1_coord;
          m_owner = p; m_phase = 5;
          exp_q.push_back({m_sp, m_sc});
        end else if (TO_EN && m_idle == TIMEOUT - 1) begin
          m_to = 1; m_phase = (p == 1) ? 3 : 4; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      5: if (result_valid) begin
        if (result_hit && m_hits[m_owner] < HITS) m_hits[m_owner]++;
        if (result_hit && m_hits[m_owner] == HITS) begin
          m_phase = 6; m_winner = m_owner + 1;
        end else begin
          m_phase = (m_owner == 1) ? 3 : 4; m_idle = 0;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    check("state", state, m_phase);
    check("shot_valid", shot_valid, m_sv);
    check("shot_player", shot_player, m_sp);
    check("shot_coord", shot_coord, m_sc);
    check("p1_hits", p1_hits, m_hits[0]);
    check("p2_hits", p2_hits, m_hits[1]);
    check("winner", winner, m_winner);
    check("turn_timeout", turn_timeout, m_to);
    if (shot_valid === 1'b1) begin
      if (exp_q.size() == 0) check("shot_q_empty", 1, 0);
      else check("shot_q", {shot_player, shot_coord}, exp_q.pop_front());
    end
  endtask

  // driver tasks: inputs change at negedge, model steps at posedge, outputs checked at negedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    start = 0; p1_place_done = 0; p2_place_done = 0;
    p1_fire_req = 0; p2_fire_req = 0; result_valid = 0; result_hit = 0;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic place_both();
    p1_place_done = 1; cycle();
    check("place_p2", state, 2);
    p2_place_done = 1; cycle();
    check("place_turn", state, 3);
    p1_place_done = 0; p2_place_done = 0;
  endtask

  task automatic fire(input bit p, input logic [COORD_W-1:0] c);
    if (p) begin p2_fire_req = 1; p2_coord = c; end
    else   begin p1_fire_req = 1; p1_coord = c; end
    cycle();
    p1_fire_req = 0; p2_fire_req = 0;
  endtask

  task automatic resolve(input bit hit);
    result_valid = 1; result_hit = hit; cycle();
    result_valid = 0; result_hit = 0;
  endtask

  task automatic async_reset();
    #2 reset = 0;
    #1;
    check("ar_state", state, 0);
    check("ar_shot_valid", shot_valid, 0);
    check("ar_shot_player", shot_player, 0);
    check("ar_shot_coord", shot_coord, 0);
    check("ar_p1_hits", p1_hits, 0);
    check("ar_p2_hits", p2_hits, 0);
    check("ar_winner", winner, 0);
    check("ar_timeout", turn_timeout, 0);
    model_reset();
    cycle(); cycle();
    reset = 1;
  endtask

  initial begin
    int shots;
    reset = 0; clear_inputs(); p1_coord = '0; p2_coord = '0;
    model_reset();
    repeat (2) cycle();
    check("rst_state", state, 0);
    check("rst_winner", winner, 0);
    reset = 1;
    cycle();

    // start and placement walk through states 1,2,3
    pulse_start();
    check("start_p1place", state, 1);
    place_both();
    check("place_hits", {p1_hits, p2_hits}, 0);

    // both request in P1 turn: owner wins
    p1_fire_req = 1; p2_fire_req = 1; p1_coord = 6'h2A; p2_coord = 6'h15;
    cycle();
    p1_fire_req = 0; p2_fire_req = 0;
    check("t3_sv", shot_valid, 1);
    check("t3_player", shot_player, 0);
    check("t3_coord", shot_coord, 6'h2A);
    check("t3_state", state, 5);
    resolve(1);
    check("t3_hits", p1_hits, 1);
    check("t3_state2", state, 4);

    // wrong player's request ignored in P2 turn
    shots = 0;
    p1_fire_req = 1;
    for (int i = 0; i < (TO_EN ? TIMEOUT - 1 : 20); i++) begin
      cycle();
      shots += int'(shot_valid);
    end
    p1_fire_req = 0;
    check("t5_shots", shots, 0);
    check("t5_state", state, 4);
    fire(1, 6'h07);
    resolve(0);
    check("t5_state2", state, 3);
    check("t5_hits", {p1_hits, p2_hits}, {5'd1, 5'd0});

    // start mid-game ignored; fresh game with three P1 hits
    pulse_start();
    check("start_ignored", state, 3);
    fire(0, 6'h01); resolve(1);
    fire(1, 6'h02); resolve(0);
    fire(0, 6'h03); resolve(1);
    check("over_state", state, 6);
    check("over_winner", winner, 1);
    pulse_start();
    check("restart_state", state, 1);
    check("restart_hits", {p1_hits, p2_hits, winner}, 0);
    place_both();
    for (int i = 0; i < 3; i++) begin
      fire(0, COORD_W'(i + 8)); resolve(1);
      if (i < 2) begin fire(1, 6'h3F); resolve(0); end
    end
    check("t4_state", state, 6);
    check("t4_winner", winner, 1);
    resolve(1);
    check("t4_saturate", p1_hits, HITS);
    pulse_start();
    check("t4_restart", {29'd0, state}, 1);

    // reset while a result is pending
    place_both();
    fire(0, 6'h11); resolve(1);
    fire(1, 6'h22);
    check("t1_pre", state, 5);
    async_reset();
    resolve(1);
    check("t1_ignored", state, 0);
    check("t1_hits", p1_hits, 0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 29) == 0);
      p1_place_done = ($urandom_range(0, 2) != 0);
      p2_place_done = ($urandom_range(0, 2) != 0);
      p1_fire_req   = ($urandom_range(0, 2) == 0);
      p2_fire_req   = ($urandom_range(0, 2) == 0);
      p1_coord      = COORD_W'($urandom);
      p2_coord      = COORD_W'($urandom);
      result_valid  = ($urandom_range(0, 2) == 0);
      result_hit    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle();
    end
    clear_inputs();
    cycle();

`ifdef TURN_TIMEOUT_EN
    // idle P1 turn forfeits after TIMEOUT cycles
    async_reset();
    pulse_start();
    place_both();
    shots = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle();
      shots += int'(shot_valid);
      check("t6_pulse", turn_timeout, (k == TIMEOUT));
    end
    check("t6_state", state, 4);
    check("t6_shots", shots, 0);
`endif

    check("shot_q_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
